// File: rtl/wb_regfile_if.sv
// Write-back, decode-read, debug and commit-trace signals of the GPR file.
// master = pipeline / harness side, slave = the register file.
interface wb_regfile_if #(
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int CNT_W = 64
);
  logic             wreg_i;
  logic [AW-1:0]    rd_addr_i;
  logic [XLEN-1:0]  wdata_i;
  logic             rs1_re_i;
  logic [AW-1:0]    rs1_addr_i;
  logic [XLEN-1:0]  rs1_data_o;
  logic             rs2_re_i;
  logic [AW-1:0]    rs2_addr_i;
  logic [XLEN-1:0]  rs2_data_o;
  logic [AW-1:0]    dbg_addr_i;
  logic [XLEN-1:0]  dbg_data_o;
  logic             commit_valid_o;
  logic [AW-1:0]    commit_rd_o;
  logic [XLEN-1:0]  commit_data_o;
  logic [CNT_W-1:0] wb_count_o;

  modport master (
    output wreg_i, rd_addr_i, wdata_i,
    output rs1_re_i, rs1_addr_i, rs2_re_i, rs2_addr_i, dbg_addr_i,
    input  rs1_data_o, rs2_data_o, dbg_data_o,
    input  commit_valid_o, commit_rd_o, commit_data_o, wb_count_o
  );

  modport slave (
    input  wreg_i, rd_addr_i, wdata_i,
    input  rs1_re_i, rs1_addr_i, rs2_re_i, rs2_addr_i, dbg_addr_i,
    output rs1_data_o, rs2_data_o, dbg_data_o,
    output commit_valid_o, commit_rd_o, commit_data_o, wb_count_o
  );
endinterface

// File: rtl/wb_regfile.sv
// 32 x XLEN GPR file with two bypassed read ports, an unbypassed debug port,
// a registered commit trace and a committed-write counter.
module wb_regfile #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input logic          clk,
  input logic          rst,
  wb_regfile_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]  gpr_q [NREG];
  logic [XLEN-1:0]  gpr_d [NREG];
  logic             commit_valid_q, commit_valid_d;
  logic [AW-1:0]    commit_rd_q, commit_rd_d;
  logic [XLEN-1:0]  commit_data_q, commit_data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accepted;

  assign accepted = bus.wreg_i && (bus.rd_addr_i != '0);

  always_comb begin
    gpr_d          = gpr_q;
    commit_valid_d = accepted;
    commit_rd_d    = commit_rd_q;
    commit_data_d  = commit_data_q;
    count_d        = count_q;
    if (accepted) begin
      gpr_d[bus.rd_addr_i] = bus.wdata_i;
      commit_rd_d          = bus.rd_addr_i;
      commit_data_d        = bus.wdata_i;
      count_d              = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_q          <= '{default: '0};
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_data_q  <= '0;
      count_q        <= '0;
    end else begin
      gpr_q          <= gpr_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_data_q  <= commit_data_d;
      count_q        <= count_d;
    end
  end

  // Read ports forward the in-flight write so decode sees it in the same cycle.
  always_comb begin
    bus.rs1_data_o = '0;
    if (bus.rs1_re_i && bus.rs1_addr_i != '0) begin
      if (accepted && bus.rd_addr_i == bus.rs1_addr_i) bus.rs1_data_o = bus.wdata_i;
      else                                             bus.rs1_data_o = gpr_q[bus.rs1_addr_i];
    end
  end

  always_comb begin
    bus.rs2_data_o = '0;
    if (bus.rs2_re_i && bus.rs2_addr_i != '0) begin
      if (accepted && bus.rd_addr_i == bus.rs2_addr_i) bus.rs2_data_o = bus.wdata_i;
      else                                             bus.rs2_data_o = gpr_q[bus.rs2_addr_i];
    end
  end

  always_comb begin
    bus.dbg_data_o = '0;
    if (bus.dbg_addr_i != '0) bus.dbg_data_o = gpr_q[bus.dbg_addr_i];
  end

  assign bus.commit_valid_o = commit_valid_q;
  assign bus.commit_rd_o    = commit_rd_q;
  assign bus.commit_data_o  = commit_data_q;
  assign bus.wb_count_o     = count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic checked against an architectural array model.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_regfile_if #(.XLEN(64), .AW(5), .CNT_W(64)) bus ();
  wb_regfile #(.XLEN(64), .NREG(32), .CNT_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] model [32];
  logic [63:0] exp_cnt;
  logic        exp_cv;
  logic [4:0]  exp_rd;
  logic [63:0] exp_data;

  function automatic logic [63:0] exp_read(input logic re, input logic [4:0] addr);
    if (!re || addr == 5'd0) return 64'd0;
    if (bus.wreg_i && bus.rd_addr_i != 5'd0 && bus.rd_addr_i == addr) return bus.wdata_i;
    return model[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    exp_cnt = 64'd0; exp_cv = 1'b0; exp_rd = 5'd0; exp_data = 64'd0;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [63:0] wd,
                       input logic re1, input logic [4:0] a1,
                       input logic re2, input logic [4:0] a2, input logic [4:0] da);
    bus.wreg_i = we; bus.rd_addr_i = rd; bus.wdata_i = wd;
    bus.rs1_re_i = re1; bus.rs1_addr_i = a1;
    bus.rs2_re_i = re2; bus.rs2_addr_i = a2;
    bus.dbg_addr_i = da;
  endtask

  // Advance one rising edge and apply the architectural effect of the driven inputs.
  task automatic tick();
    logic we; logic [4:0] rd; logic [63:0] wd;
    we = bus.wreg_i; rd = bus.rd_addr_i; wd = bus.wdata_i;
    @(posedge clk);
    if (rst) begin
      exp_cv = 1'b0;
    end else if (we && rd != 5'd0) begin
      model[rd] = wd; exp_cnt = exp_cnt + 64'd1;
      exp_cv = 1'b1; exp_rd = rd; exp_data = wd;
    end else begin
      exp_cv = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    drive(1'b1, 5'd5, 64'hFFFF_0000_FFFF_0000, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
    tick(); tick();
    n_cmp++;
    if (bus.dbg_data_o !== 64'd0 || bus.wb_count_o !== 64'd0 || bus.commit_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: dbg=%h cnt=%0d cv=%b required 0/0/0",
               bus.dbg_data_o, bus.wb_count_o, bus.commit_valid_o);
    end
    rst = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr_i = 5'(i); bus.rs2_addr_i = 5'(i); bus.dbg_addr_i = 5'(i);
      #1;
      n_cmp++;
      if (bus.rs1_data_o !== 64'd0 || bus.rs2_data_o !== 64'd0 || bus.dbg_data_o !== 64'd0) begin
        n_err++;
        $display("FAIL reset_gpr x%0d: rs1=%h rs2=%h dbg=%h required 0", i,
                 bus.rs1_data_o, bus.rs2_data_o, bus.dbg_data_o);
      end
    end
    n_cmp++;
    if (bus.wb_count_o !== 64'd0 || bus.commit_valid_o !== 1'b0 ||
        bus.commit_rd_o !== 5'd0 || bus.commit_data_o !== 64'd0) begin
      n_err++;
      $display("FAIL reset_trace: cnt=%0d cv=%b rd=%0d data=%h required all 0",
               bus.wb_count_o, bus.commit_valid_o, bus.commit_rd_o, bus.commit_data_o);
    end
  endtask

  task automatic test_bypass_write();
    drive(1'b1, 5'd5, 64'hDEADBEEF_00000001, 1'b1, 5'd5, 1'b0, 5'd5, 5'd5);
    #1;
    n_cmp++;
    if (bus.rs1_data_o !== 64'hDEADBEEF_00000001) begin
      n_err++; $display("FAIL bypass_rs1: got %h required %h", bus.rs1_data_o, 64'hDEADBEEF_00000001);
    end
    n_cmp++;
    if (bus.dbg_data_o !== 64'd0) begin
      n_err++; $display("FAIL dbg_no_bypass: got %h required 0", bus.dbg_data_o);
    end
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
    #1;
    n_cmp++;
    if (bus.dbg_data_o !== 64'hDEADBEEF_00000001 || bus.commit_valid_o !== 1'b1 ||
        bus.commit_rd_o !== 5'd5 || bus.commit_data_o !== 64'hDEADBEEF_00000001 ||
        bus.wb_count_o !== 64'd1) begin
      n_err++;
      $display("FAIL write_x5: dbg=%h cv=%b rd=%0d data=%h cnt=%0d required %h/1/5/%h/1",
               bus.dbg_data_o, bus.commit_valid_o, bus.commit_rd_o, bus.commit_data_o,
               bus.wb_count_o, 64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001);
    end
    tick();
    n_cmp++;
    if (bus.commit_valid_o !== 1'b0 || bus.commit_rd_o !== 5'd5) begin
      n_err++;
      $display("FAIL commit_pulse: cv=%b rd=%0d required 0/5", bus.commit_valid_o, bus.commit_rd_o);
    end
  endtask

  task automatic test_x0_write();
    logic [63:0] cnt0;
    cnt0 = exp_cnt;
    drive(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    #1;
    n_cmp++;
    if (bus.rs1_data_o !== 64'd0 || bus.rs2_data_o !== 64'd0) begin
      n_err++; $display("FAIL x0_bypass: rs1=%h rs2=%h required 0", bus.rs1_data_o, bus.rs2_data_o);
    end
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    #1;
    n_cmp++;
    if (bus.dbg_data_o !== 64'd0 || bus.rs1_data_o !== 64'd0 ||
        bus.commit_valid_o !== 1'b0 || bus.wb_count_o !== cnt0) begin
      n_err++;
      $display("FAIL x0_drop: dbg=%h rs1=%h cv=%b cnt=%0d required 0/0/0/%0d",
               bus.dbg_data_o, bus.rs1_data_o, bus.commit_valid_o, bus.wb_count_o, cnt0);
    end
  endtask

  task automatic test_read_enable();
    drive(1'b1, 5'd7, 64'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 1'b1, 5'd7, 5'd7);
    #1;
    n_cmp++;
    if (bus.rs1_data_o !== 64'd0 || bus.rs2_data_o !== 64'h1234) begin
      n_err++;
      $display("FAIL read_enable: rs1=%h rs2=%h required 0/1234", bus.rs1_data_o, bus.rs2_data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rds [3] = '{5'd1, 5'd2, 5'd1};
    logic [63:0] wds [3] = '{64'd1, 64'd2, 64'd3};
    logic [63:0] cnt0;
    cnt0 = exp_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rds[i], wds[i], 1'b1, 5'd1, 1'b1, 5'd2, 5'd1);
      if (i > 0) begin
        n_cmp++;
        if (bus.commit_valid_o !== 1'b1 || bus.commit_rd_o !== rds[i-1]) begin
          n_err++;
          $display("FAIL b2b_commit[%0d]: cv=%b rd=%0d required 1/%0d", i - 1,
                   bus.commit_valid_o, bus.commit_rd_o, rds[i-1]);
        end
      end
      tick();
    end
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd1, 1'b1, 5'd2, 5'd1);
    #1;
    n_cmp++;
    if (bus.commit_valid_o !== 1'b1 || bus.commit_rd_o !== 5'd1 || bus.commit_data_o !== 64'd3) begin
      n_err++;
      $display("FAIL b2b_commit[2]: cv=%b rd=%0d data=%h required 1/1/3",
               bus.commit_valid_o, bus.commit_rd_o, bus.commit_data_o);
    end
    n_cmp++;
    if (bus.rs1_data_o !== 64'd3 || bus.rs2_data_o !== 64'd2 || bus.wb_count_o !== cnt0 + 64'd3) begin
      n_err++;
      $display("FAIL b2b_state: x1=%h x2=%h cnt=%0d required 3/2/%0d",
               bus.rs1_data_o, bus.rs2_data_o, bus.wb_count_o, cnt0 + 64'd3);
    end
    tick();
    n_cmp++;
    if (bus.commit_valid_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: cv=%b required 0", bus.commit_valid_o);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 5'd3, 64'd9, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    tick();
    n_cmp++;
    if (bus.dbg_data_o !== 64'd9 || bus.commit_valid_o !== 1'b1 || bus.wb_count_o !== exp_cnt) begin
      n_err++;
      $display("FAIL preload_x3: dbg=%h cv=%b cnt=%0d required 9/1/%0d",
               bus.dbg_data_o, bus.commit_valid_o, bus.wb_count_o, exp_cnt);
    end
    rst = 1'b1;
    model_reset();
    drive(1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 1'b0, 5'd0, 5'd3);
    #1;
    n_cmp++;
    if (bus.dbg_data_o !== 64'd0 || bus.commit_valid_o !== 1'b0 ||
        bus.wb_count_o !== 64'd0 || bus.commit_data_o !== 64'd0) begin
      n_err++;
      $display("FAIL async_reset: dbg=%h cv=%b cnt=%0d data=%h required 0",
               bus.dbg_data_o, bus.commit_valid_o, bus.wb_count_o, bus.commit_data_o);
    end
    tick(); tick();
    rst = 1'b0;
    drive(1'b1, 5'd3, 64'h55, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    #1;
    n_cmp++;
    if (bus.dbg_data_o !== 64'd0 || bus.wb_count_o !== 64'd0) begin
      n_err++;
      $display("FAIL reset_no_write: x3=%h cnt=%0d required 0/0", bus.dbg_data_o, bus.wb_count_o);
    end
    tick();
    n_cmp++;
    if (bus.dbg_data_o !== 64'h55 || bus.wb_count_o !== 64'd1 || bus.commit_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL first_write: x3=%h cnt=%0d cv=%b required 55/1/1",
               bus.dbg_data_o, bus.wb_count_o, bus.commit_valid_o);
    end
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_random();
    logic [4:0] rd;
    for (int n = 0; n < 400; n++) begin
      rd = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), rd, {$urandom, $urandom},
            1'($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      #1;
      n_cmp++;
      if (bus.rs1_data_o !== exp_read(bus.rs1_re_i, bus.rs1_addr_i) ||
          bus.rs2_data_o !== exp_read(bus.rs2_re_i, bus.rs2_addr_i) ||
          bus.dbg_data_o !== model[bus.dbg_addr_i]) begin
        n_err++;
        $display("FAIL rand_read[%0d]: rs1=%h/%h rs2=%h/%h dbg=%h/%h (got/required)", n,
                 bus.rs1_data_o, exp_read(bus.rs1_re_i, bus.rs1_addr_i),
                 bus.rs2_data_o, exp_read(bus.rs2_re_i, bus.rs2_addr_i),
                 bus.dbg_data_o, model[bus.dbg_addr_i]);
      end
      tick();
      n_cmp++;
      if (bus.commit_valid_o !== exp_cv || bus.commit_rd_o !== exp_rd ||
          bus.commit_data_o !== exp_data || bus.wb_count_o !== exp_cnt) begin
        n_err++;
        $display("FAIL rand_trace[%0d]: cv=%b/%b rd=%0d/%0d data=%h/%h cnt=%0d/%0d (got/required)", n,
                 bus.commit_valid_o, exp_cv, bus.commit_rd_o, exp_rd,
                 bus.commit_data_o, exp_data, bus.wb_count_o, exp_cnt);
      end
    end
  endtask

  initial begin
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    test_reset();
    test_bypass_write();
    test_x0_write();
    test_read_enable();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
